// File: rtl/md_pkg.sv
// Shared types and opcode classification for the EXE-stage multiply/divide unit.
package md_pkg;

    typedef enum logic [3:0] {
        MULT  = 4'd0,
        MULTU = 4'd1,
        DIV   = 4'd2,
        DIVU  = 4'd3,
        MTHI  = 4'd4,
        MTLO  = 4'd5,
        MADD  = 4'd6,
        MADDU = 4'd7,
        MSUB  = 4'd8,
        MSUBU = 4'd9,
        NOP   = 4'd10
    } md_op_e;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } md_state_e;

    function automatic logic is_mul(input md_op_e op);
        return (op == MULT) || (op == MULTU) || (op == MADD) ||
               (op == MADDU) || (op == MSUB) || (op == MSUBU);
    endfunction

    function automatic logic is_div(input md_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. The result is computed in one step at
// accept time and held in res_hi/res_lo until the latency counter expires.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  md_op_e           op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             flush,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    // Low 2*WIDTH bits of the product of the extended operands equal the true product.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                    input logic [WIDTH-1:0] b,
                                                    input logic             sgn);
        logic [2*WIDTH-1:0] ea;
        logic [2*WIDTH-1:0] eb;
        ea = sgn ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        eb = sgn ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}; a zero divisor leaves the current {hi,lo} in place.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0]   a,
                                                    input logic [WIDTH-1:0]   b,
                                                    input logic               sgn,
                                                    input logic [2*WIDTH-1:0] cur);
        logic signed [WIDTH-1:0] sa;
        logic signed [WIDTH-1:0] sb;
        logic signed [WIDTH-1:0] sq;
        logic signed [WIDTH-1:0] sr;
        if (b == '0)
            return cur;
        if (sgn) begin
            if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == '1)
                return {{WIDTH{1'b0}}, a};
            sa = a;
            sb = b;
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        return {a % b, a / b};
    endfunction

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic [WIDTH-1:0]   res_hi, res_lo;
    logic [2*WIDTH-1:0] acc, prod, res_d;
    logic               sgn, accept, commit, mt_hi, mt_lo;

    always_comb begin
        acc   = {hi_q, lo_q};
        sgn   = (op == MULT) || (op == MADD) || (op == MSUB);
        prod  = mul_full(rs_val, rt_val, sgn);
        res_d = prod;
        case (op)
            MADD, MADDU: res_d = acc + prod;
            MSUB, MSUBU: res_d = acc - prod;
            DIV:         res_d = div_full(rs_val, rt_val, 1'b1, acc);
            DIVU:        res_d = div_full(rs_val, rt_val, 1'b0, acc);
            default:     res_d = prod;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && !flush) begin
                    if (is_mul(op) || is_div(op)) begin
                        accept  = 1'b1;
                        state_d = RUN;
                        cnt_d   = is_div(op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
                    end
                    mt_hi = (op == MTHI);
                    mt_lo = (op == MTLO);
                end
            end
            RUN: begin
                // Flush beats completion, so a flushed op never reaches HI/LO.
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (commit) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end else begin
                if (mt_hi)
                    hi_q <= rs_val;
                if (mt_lo)
                    lo_q <= rs_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            res_hi <= res_d[2*WIDTH-1:WIDTH];
            res_lo <= res_d[WIDTH-1:0];
        end
    end

    assign busy = (state_q == RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver pushes expected HI/LO and busy length, a
// negedge monitor pops and compares whenever an operation finishes.
module tb_md_unit;
    import md_pkg::*;

    localparam int W  = 32;
    localparam int ML = 5;
    localparam int DL = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    md_op_e      op = NOP;
    logic [31:0] rs_val = '0;
    logic [31:0] rt_val = '0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    exp_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          bcnt = 0;
    bit          zero_pend = 1'b0;
    logic [31:0] mhi = '0;
    logic [31:0] mlo = '0;

    md_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
        .clk    (clk),
        .reset  (reset_n),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .flush  (flush),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural HI/LO pair.
    task automatic model(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, acc, p, res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        acc = {mhi, mlo};
        lat = ML;
        res = acc;
        case (o)
            MULT:  res = longint'(sa * sb);
            MULTU: res = ua * ub;
            MADD:  begin p = longint'(sa * sb); res = acc + p; end
            MADDU: res = acc + ua * ub;
            MSUB:  begin p = longint'(sa * sb); res = acc - p; end
            MSUBU: res = acc - ua * ub;
            DIV: begin
                lat = DL;
                if (b != 0) begin
                    q = sa / sb;
                    r = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            DIVU: begin
                lat = DL;
                if (b != 0)
                    res = {32'(ua % ub), 32'(ua / ub)};
            end
            MTHI:    begin lat = 0; res = {a, mlo}; end
            MTLO:    begin lat = 0; res = {mhi, a}; end
            default: lat = 0;
        endcase
        mhi = res[63:32];
        mlo = res[31:0];
    endtask

    // fk > 0: flush at the fk-th busy cycle; fl_idle: raise flush together with start.
    task automatic issue(input md_op_e o, input logic [31:0] a, input logic [31:0] b,
                         input int fk, input bit fl_idle, input string nm);
        int          lat;
        int          g;
        logic [31:0] ohi, olo;
        exp_t        e;
        @(negedge clk);
        op = o; rs_val = a; rt_val = b; start = 1'b1; flush = fl_idle;
        ohi = mhi; olo = mlo;
        if (fl_idle)
            lat = 0;
        else
            model(o, a, b, lat);
        if (fk > 0 && lat > 0) begin
            mhi = ohi; mlo = olo;
            lat = fk;
        end
        e.hi = mhi; e.lo = mlo; e.lat = lat; e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        if (lat == 0)
            zero_pend = 1'b1;
        if (fk > 0 && lat > 0) begin
            repeat (fk) @(negedge clk);
            flush = 1'b1;
            @(posedge clk);
            #1 flush = 1'b0;
        end
        g = 0;
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: busy still %b after %0d cycles, required 0", nm, busy, g);
        end
        @(negedge clk);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            bcnt = 0;
            zero_pend = 1'b0;
        end else begin
            if (start)
                chk("start_while_busy", {31'd0, busy}, 32'd0);
            if (busy) begin
                bcnt++;
            end else if (bcnt > 0 || zero_pend) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: busy ran %0d cycles, required no operation", bcnt);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk({e.name, "_hi"}, hi, e.hi);
                    chk({e.name, "_lo"}, lo, e.lo);
                    chk({e.name, "_busy_cycles"}, 32'(bcnt), 32'(e.lat));
                end
                bcnt = 0;
                zero_pend = 1'b0;
            end
        end
    end

    initial begin
        md_op_e ro;
        int     rl, fk;
        bit     fi;

        #2;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        issue(MULT, 32'hFFFF_FFFD, 32'h5, 0, 0, "t1_mult");
        chk("t1_hi", hi, 32'hFFFF_FFFF);
        chk("t1_lo", lo, 32'hFFFF_FFF1);

        issue(DIVU, 32'd100, 32'd7, 0, 0, "t2_divu");
        chk("t2_divu_lo", lo, 32'd14);
        chk("t2_divu_hi", hi, 32'd2);
        issue(DIV, 32'hFFFF_FFF9, 32'd2, 0, 0, "t2_div");
        chk("t2_div_lo", lo, 32'hFFFF_FFFD);
        chk("t2_div_hi", hi, 32'hFFFF_FFFF);

        issue(MTHI, 32'h1234, 32'h0, 0, 0, "t3_mthi");
        issue(MTLO, 32'h5678, 32'h0, 0, 0, "t3_mtlo");
        issue(MADDU, 32'h1_0000, 32'h1_0000, 0, 0, "t3_maddu");
        chk("t3_maddu_hi", hi, 32'h1235);
        chk("t3_maddu_lo", lo, 32'h5678);
        issue(MSUB, 32'd1, 32'd1, 0, 0, "t3_msub");
        chk("t3_msub_lo", lo, 32'h5677);

        issue(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "t4_minint");
        chk("t4_minint_lo", lo, 32'h8000_0000);
        chk("t4_minint_hi", hi, 32'h0);
        issue(MTHI, 32'hA, 32'h0, 0, 0, "t4_mthi");
        issue(MTLO, 32'hB, 32'h0, 0, 0, "t4_mtlo");
        issue(DIV, 32'd5, 32'd0, 0, 0, "t4_div0");
        chk("t4_div0_hi", hi, 32'hA);
        chk("t4_div0_lo", lo, 32'hB);

        issue(MULT, 32'd3, 32'd4, 3, 0, "t5_flush3");
        issue(MULT, 32'd3, 32'd4, ML, 0, "t5_flush_last");
        issue(MULT, 32'd3, 32'd4, 0, 1, "t5_flush_idle");
        issue(md_op_e'(4'd13), 32'h77, 32'h77, 0, 0, "t5_unknown");
        chk("t5_hi", hi, 32'hA);
        chk("t5_lo", lo, 32'hB);

        // Asynchronous reset in the middle of a divide, outside the scoreboard.
        @(negedge clk);
        op = DIV; rs_val = 32'd1000; rt_val = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_reset_busy", {31'd0, busy}, 32'd0);
        chk("t6_reset_hi", hi, 32'd0);
        chk("t6_reset_lo", lo, 32'd0);
        exp_q.delete();
        mhi = '0; mlo = '0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        issue(MULT, 32'd2, 32'd2, 0, 0, "t6_mult");
        chk("t6_mult_lo", lo, 32'd4);

        for (int i = 0; i < 80; i++) begin
            ro = md_op_e'(4'($urandom_range(0, 15)));
            rl = is_div(ro) ? DL : (is_mul(ro) ? ML : 0);
            fk = 0;
            fi = ($urandom_range(0, 9) == 0);
            if (!fi && rl > 0 && $urandom_range(0, 5) == 0)
                fk = $urandom_range(1, rl);
            issue(ro, rnd_val(), rnd_val(), fk, fi, $sformatf("rnd%0d_%s", i, ro.name()));
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
